ulpi_reg_ctrl: RTL and testbench
================================

// Module: ulpi_reg_ctrl
// PURPOSE
//  Sequences ULPI PHY register reads/writes over the link's TX command path.
//  Accepts one register request at a time from the system side and drives
//  cmd/cmd_strobe (to the link's sys_cmd/sys_cmd_strobe) plus ulpi_stp.
//  Tracks dir/nxt to step TX CMD -> data -> STP, or TX CMD -> turnaround -> read data.
//  Retries a request after PHY abort; reports timeout or retry exhaustion as an error.
// PARAMETERS
//  TIMEOUT      64  max cycles waiting for nxt/dir in any wait state; must be 2..255
//  MAX_RETRIES  3   PHY aborts tolerated per request before err; 0 = no retry
// PORTS
//  clk            in   1  ULPI 60 MHz clock (ulpi.clk); sole clock
//  reset          in   1  synchronous, active-high
//  req            in   1  request valid; accepted on the cycle req && !busy
//  we             in   1  1 = register write, 0 = register read (sampled at accept)
//  addr           in   6  immediate register address (sampled at accept)
//  wdata          in   8  write data (sampled at accept)
//  busy           out  1  high from the cycle after accept through the done cycle
//  done           out  1  one-cycle completion pulse
//  err            out  1  valid with done: 1 = timeout, retry limit or unsupported address
//  rdata          out  8  read result; updated only on a successful read done
//  ulpi_dir       in   1  PHY dir
//  ulpi_nxt       in   1  PHY nxt
//  ulpi_data_in   in   8  ULPI data bus as seen by the link (input direction)
//  cmd            out  8  byte for the link to drive (sys_cmd)
//  cmd_strobe     out  1  drive cmd instead of NOOP (sys_cmd_strobe)
//  ulpi_stp       out  1  PHY stp
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, err, cmd_strobe, ulpi_stp = 0; cmd, rdata = 8'h00;
//    retry and timeout counters = 0. Reset mid-transfer abandons it without driving stp.
//  - dir_r is a registered copy of ulpi_dir.
//    own_bus = !ulpi_dir && (ulpi_dir == dir_r): link owns the bus, no turnaround.
//  - cmd_strobe is asserted only in TXCMD/WDATA with own_bus (combinational on dir).
//  - States and transitions:
//    IDLE: on req -> latch we/addr/wdata; addr==6'h2F (extended) -> DONE with err=1;
//      otherwise -> TXCMD. req while busy is ignored; requests are not queued.
//    TXCMD: cmd = we ? {2'b10,addr} : {2'b11,addr}.
//      own_bus && nxt -> WDATA (write) / RTURN (read).
//    WDATA: cmd = wdata. own_bus && nxt -> STP.
//    STP: ulpi_stp=1, cmd_strobe=0, exactly one cycle -> DONE with err=0.
//    RTURN: wait for ulpi_dir=1.
//      dir && !nxt -> RDATA. dir && nxt = PHY abort (receive takes priority).
//    RDATA: ulpi_data_in is captured into rdata this cycle.
//      Then -> DONE with err=0; a dir drop here is the PHY's normal turnaround.
//    DONE: done=1 for one cycle -> IDLE; busy falls the following cycle.
//  - Abort: ulpi_dir rising while in TXCMD or WDATA, or dir&&nxt in RTURN.
//    Increments retry; if retry > MAX_RETRIES -> DONE err=1, else -> TXCMD,
//    re-sending the command once own_bus returns.
//  - Timeout: counter clears on every state change and increments in
//    TXCMD/WDATA/RTURN. Reaching TIMEOUT -> DONE err=1; stp is not driven.
//  - Retry counter clears at accept. Latency with a PHY that asserts nxt/dir at once:
//    write accept->done = 4 cycles; read accept->done = 4 cycles.
//  - nxt and dir rising together in TXCMD counts as abort, not acceptance.
// STRUCTURE
//  - ulpi_pkg: UlpiCmd enum
//    (NOOP 8'h00, REG_WRITE 8'h80, REG_READ 8'hC0, EXT_ADDR 6'h2F),
//    and the ulpi_reg_state_t enum {IDLE,TXCMD,WDATA,STP,RTURN,RDATA,DONE}.
//    ulpi_link imports the same package for NOOP.
//  - No sub-module: one FSM plus the timeout and retry counters, in a single file.
// TESTING
//  1 write addr 6'h04 wdata 8'h45, PHY nxt 1 cycle after cmd:
//    cmd 8'h84 then 8'h45, stp for 1 cycle, done=1 err=0.
//  2 read addr 6'h0A, PHY nxt, then dir (turnaround), data 8'h5A, then dir low:
//    cmd 8'hCA, rdata=8'h5A, done err=0.
//  3 write, PHY raises dir during WDATA once then drops:
//    strobe falls the same cycle, cmd 8'h84 re-sent, completes err=0.
//  4 read with MAX_RETRIES=3 and dir&&nxt abort 4 times:
//    done err=1 after the 4th abort; rdata unchanged.
//  5 write, PHY never asserts nxt: done err=1 exactly TIMEOUT cycles after entering TXCMD.
//  6 req addr 6'h2F -> done err=1, cmd_strobe never high.
//    Reset mid-WDATA -> next cycle all outputs 0, busy=0.

Source files
------------

// File: rtl/ulpi_pkg.sv
// ulpi_pkg: ULPI register-access command bytes and the register sequencer state encoding.
package ulpi_pkg;
   typedef enum logic [7:0] {
      NOOP      = 8'h00,
      REG_WRITE = 8'h80,
      REG_READ  = 8'hC0
   } UlpiCmd;
   localparam logic [5:0] EXT_ADDR = 6'h2F;
   typedef enum logic [2:0] {IDLE, TXCMD, WDATA, STP, RTURN, RDATA, DONE} ulpi_reg_state_t;
endpackage

// File: rtl/ulpi_reg_ctrl.sv
// ulpi_reg_ctrl: sequences one ULPI PHY register read or write at a time over the link TX path,
// retrying after PHY aborts and flagging timeouts, retry exhaustion and extended addresses.
module ulpi_reg_ctrl
   import ulpi_pkg::*;
#(
   parameter int TIMEOUT     = 64,
   parameter int MAX_RETRIES = 3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req,
   input  logic       we,
   input  logic [5:0] addr,
   input  logic [7:0] wdata,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [7:0] rdata,
   input  logic       ulpi_dir,
   input  logic       ulpi_nxt,
   input  logic [7:0] ulpi_data_in,
   output logic [7:0] cmd,
   output logic       cmd_strobe,
   output logic       ulpi_stp
);
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
   localparam logic [7:0] MAX_R   = 8'(MAX_RETRIES);
   ulpi_reg_state_t state_q, state_d;
   logic [7:0] to_q, to_d, retry_q, retry_d, rdata_q, rdata_d, wdata_q, wdata_d;
   logic [5:0] addr_q, addr_d;
   logic       we_q, we_d, err_q, err_d, dir_q, own_bus, dir_rise, abort, waiting;
   // The link may only drive when dir is low and was low last cycle (no turnaround in progress).
   assign own_bus  = !ulpi_dir && (ulpi_dir == dir_q);
   assign dir_rise = ulpi_dir && !dir_q;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         to_q    <= '0;
         retry_q <= '0;
         rdata_q <= '0;
         wdata_q <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         to_q    <= to_d;
         retry_q <= retry_d;
         rdata_q <= rdata_d;
         wdata_q <= wdata_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         err_q   <= err_d;
         dir_q   <= ulpi_dir;
      end
   end
   always_comb begin
      state_d = state_q;
      err_d   = 1'b0;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      retry_d = retry_q;
      abort   = 1'b0;
      waiting = state_q inside {TXCMD, WDATA, RTURN};
      case (state_q)
         IDLE:
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               wdata_d = wdata;
               retry_d = '0;
               err_d   = addr == EXT_ADDR;
               state_d = (addr == EXT_ADDR) ? DONE : TXCMD;
            end
         TXCMD:
            if (dir_rise) abort = 1'b1;
            else if (own_bus && ulpi_nxt) state_d = we_q ? WDATA : RTURN;
         WDATA:
            if (dir_rise) abort = 1'b1;
            else if (own_bus && ulpi_nxt) state_d = STP;
         STP: state_d = DONE;
         RTURN:
            if (ulpi_dir && ulpi_nxt) abort = 1'b1;
            else if (ulpi_dir) state_d = RDATA;
         RDATA: begin
            rdata_d = ulpi_data_in;
            state_d = DONE;
         end
         default: state_d = IDLE;
      endcase
      if (abort) begin
         retry_d = retry_q + 8'd1;
         err_d   = retry_d > MAX_R;
         state_d = (retry_d > MAX_R) ? DONE : TXCMD;
      end else if (waiting && state_d == state_q && to_q >= TO_LAST) begin
         err_d   = 1'b1;
         state_d = DONE;
      end
      to_d = (state_d != state_q) ? '0 : waiting ? to_q + 8'd1 : '0;
   end
   always_comb begin
      busy       = state_q != IDLE;
      done       = state_q == DONE;
      err        = err_q;
      rdata      = rdata_q;
      ulpi_stp   = state_q == STP;
      cmd_strobe = (state_q == TXCMD || state_q == WDATA) && own_bus;
      cmd        = (state_q == TXCMD) ? ((we_q ? REG_WRITE : REG_READ) | {2'b00, addr_q})
                 : (state_q == WDATA) ? wdata_q : NOOP;
   end
endmodule

// File: tb/tb_ulpi_reg_ctrl.sv
// tb_ulpi_reg_ctrl: table, random and hand-sequenced checks of ulpi_reg_ctrl against a
// transaction-level model driven by a reactive PHY.
module tb_ulpi_reg_ctrl;
   localparam int TIMEOUT = 64;
   localparam int MAX_RETRIES = 3;
   typedef struct {
      logic we; logic [5:0] addr; logic [7:0] wd, rd;
      int d1, d2, d3, lat;
      logic err; logic [7:0] cmd, rdx;
   } vec_t;
   logic clk = 1'b0, reset = 1'b1, req = 1'b0, we = 1'b0;
   logic [5:0] addr = '0;
   logic [7:0] wdata = '0, ulpi_data_in = '0;
   logic ulpi_dir = 1'b0, ulpi_nxt = 1'b0;
   logic busy, done, err, cmd_strobe, ulpi_stp;
   logic [7:0] rdata, cmd;
   int errors = 0, checks = 0;
   logic [7:0] cur_rd = 8'h00;
   vec_t tbl[7];

   ulpi_reg_ctrl #(.TIMEOUT(TIMEOUT), .MAX_RETRIES(MAX_RETRIES)) dut (
      .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy), .done(done), .err(err), .rdata(rdata),
      .ulpi_dir(ulpi_dir), .ulpi_nxt(ulpi_nxt), .ulpi_data_in(ulpi_data_in),
      .cmd(cmd), .cmd_strobe(cmd_strobe), .ulpi_stp(ulpi_stp)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic cyc(input logic d, input logic n, input logic [7:0] di);
      @(posedge clk);
      #1 req = 1'b0; ulpi_dir = d; ulpi_nxt = n; ulpi_data_in = di;
      #1;
   endtask

   task automatic start(input logic w, input logic [5:0] a, input logic [7:0] wd);
      req = 1'b1; we = w; addr = a; wdata = wd;
   endtask

   // Expected outcome of one transaction from the PHY response delays alone.
   function automatic vec_t model(input logic w, input logic [5:0] a, input logic [7:0] wd,
                                  input logic [7:0] rd, input int d1, input int d2, input int d3,
                                  input logic [7:0] prev_rd);
      vec_t m;
      logic ext;
      ext = a == 6'h2F;
      m.we = w; m.addr = a; m.wd = wd; m.rd = rd; m.d1 = d1; m.d2 = d2; m.d3 = d3;
      m.lat = ext ? 1 : 4 + d1 + (w ? d2 : d3);
      m.err = ext;
      m.cmd = ext ? 8'h00 : 8'((w ? 8'h80 : 8'hC0) + {2'b00, a});
      m.rdx = (w || ext) ? prev_rd : rd;
      return m;
   endfunction

   // Reactive PHY: accepts each strobed byte after d1/d2 waiting cycles, then for a read
   // raises dir after d3 cycles, presents data on the following cycle and drops dir.
   task automatic run_txn(input vec_t v);
      int phase, wc, lat, stp_n, busy_bad;
      logic [7:0] acc[$];
      logic [23:0] got_b, exp_b;
      phase = 0; wc = 0; lat = 0; stp_n = 0; busy_bad = 0;
      start(v.we, v.addr, v.wd);
      for (int k = 1; k <= 100 && lat == 0; k++) begin
         @(posedge clk);
         #1 req = 1'b0; ulpi_nxt = 1'b0; ulpi_dir = 1'b0; ulpi_data_in = 8'h00;
         case (phase)
            2: if (wc == v.d3) begin ulpi_dir = 1'b1; phase = 3; end else wc++;
            3: begin ulpi_dir = 1'b1; ulpi_data_in = v.rd; phase = 4; end
            default: ;
         endcase
         #1 if (cmd_strobe && phase < 2) begin
            if (wc == (phase == 0 ? v.d1 : v.d2)) begin
               ulpi_nxt = 1'b1;
               acc.push_back(cmd);
               wc = 0;
               phase = (phase == 1) ? 4 : v.we ? 1 : 2;
            end else wc++;
         end
         #1 stp_n += int'(ulpi_stp);
         if (!busy) busy_bad++;
         if (done) lat = k;
      end
      chk("latency", lat, v.lat);
      chk("err", err, v.err);
      chk("rdata", rdata, v.rdx);
      chk("stp_count", stp_n, (v.we && !v.err) ? 1 : 0);
      chk("busy_during", busy_bad, 0);
      exp_b = v.err ? 24'h0 : v.we ? {8'd2, v.cmd, v.wd} : {8'd1, v.cmd, 8'h00};
      got_b = {8'(acc.size()), acc.size() > 0 ? acc[0] : 8'h00, acc.size() > 1 ? acc[1] : 8'h00};
      chk("bytes", got_b, exp_b);
      cyc(1'b0, 1'b0, 8'h00);
      chk("idle_after", {busy, done}, 0);
   endtask

   initial begin
      int k, stp_n;
      tbl[0] = '{1'b1, 6'h04, 8'h45, 8'h00, 1, 0, 0, 5, 1'b0, 8'h84, 8'h00};
      tbl[1] = '{1'b0, 6'h0A, 8'h00, 8'h5A, 0, 0, 0, 4, 1'b0, 8'hCA, 8'h5A};
      tbl[2] = '{1'b1, 6'h3F, 8'hFF, 8'h00, 2, 1, 0, 7, 1'b0, 8'hBF, 8'h5A};
      tbl[3] = '{1'b0, 6'h00, 8'h00, 8'hA5, 1, 0, 2, 7, 1'b0, 8'hC0, 8'hA5};
      tbl[4] = '{1'b1, 6'h2F, 8'h12, 8'h00, 0, 0, 0, 1, 1'b1, 8'h00, 8'hA5};
      tbl[5] = '{1'b0, 6'h2F, 8'h00, 8'h77, 0, 0, 0, 1, 1'b1, 8'h00, 8'hA5};
      tbl[6] = '{1'b1, 6'h2E, 8'h81, 8'h00, 0, 0, 0, 4, 1'b0, 8'hAE, 8'hA5};
      cyc(1'b0, 1'b0, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("reset_ctrl", {busy, done, err, cmd_strobe, ulpi_stp}, 0);
      chk("reset_data", {cmd, rdata}, 0);
      reset = 1'b0;
      cyc(1'b0, 1'b0, 8'h00);
      foreach (tbl[i]) run_txn(tbl[i]);
      cur_rd = 8'hA5;
      for (int i = 0; i < 40; i++) begin
         vec_t v;
         logic [5:0] a;
         a = ($urandom_range(0, 7) == 0) ? 6'h2F : 6'($urandom_range(0, 63));
         v = model(1'($urandom_range(0, 1)), a, 8'($urandom), 8'($urandom),
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), cur_rd);
         run_txn(v);
         cur_rd = v.rdx;
      end
      // Write aborted by dir rising in the data phase, then re-sent from the command byte.
      start(1'b1, 6'h04, 8'h45);
      cyc(1'b0, 1'b1, 8'h00);
      chk("ab_w_cmd", {cmd_strobe, cmd}, {1'b1, 8'h84});
      cyc(1'b1, 1'b0, 8'h00);
      chk("ab_w_strobe_drop", cmd_strobe, 1'b0);
      cyc(1'b1, 1'b0, 8'h00);
      chk("ab_w_dir_held", cmd_strobe, 1'b0);
      cyc(1'b0, 1'b0, 8'h00);
      chk("ab_w_turnaround", cmd_strobe, 1'b0);
      cyc(1'b0, 1'b1, 8'h00);
      chk("ab_w_resend", {cmd_strobe, cmd}, {1'b1, 8'h84});
      cyc(1'b0, 1'b1, 8'h00);
      chk("ab_w_data", {cmd_strobe, cmd}, {1'b1, 8'h45});
      cyc(1'b0, 1'b0, 8'h00);
      chk("ab_w_stp", {ulpi_stp, cmd_strobe, done}, 3'b100);
      cyc(1'b0, 1'b0, 8'h00);
      chk("ab_w_done", {done, err}, 2'b10);
      cyc(1'b0, 1'b0, 8'h00);
      chk("ab_w_idle", busy, 1'b0);
      // Read aborted MAX_RETRIES+1 times fails; then MAX_RETRIES aborts still succeed.
      for (int n = MAX_RETRIES + 1; n >= MAX_RETRIES; n--) begin
         start(1'b0, 6'h0A, 8'h00);
         for (int a = 0; a < n; a++) begin
            if (a > 0) begin
               cyc(1'b0, 1'b0, 8'h00);
               chk("ab_r_turnaround", cmd_strobe, 1'b0);
            end
            cyc(1'b0, 1'b1, 8'h00);
            chk("ab_r_cmd", {cmd_strobe, cmd}, {1'b1, 8'hCA});
            cyc(1'b1, 1'b1, 8'hEE);
         end
         if (n == MAX_RETRIES) begin
            cyc(1'b0, 1'b0, 8'h00);
            cyc(1'b0, 1'b1, 8'h00);
            chk("ab_r_last_cmd", {cmd_strobe, cmd}, {1'b1, 8'hCA});
            cyc(1'b1, 1'b0, 8'h00);
            cyc(1'b1, 1'b0, 8'h3C);
            cur_rd = 8'h3C;
         end
         cyc(1'b0, 1'b0, 8'h00);
         chk("ab_r_done", {done, err}, {1'b1, n > MAX_RETRIES});
         chk("ab_r_rdata", rdata, cur_rd);
         cyc(1'b0, 1'b0, 8'h00);
         chk("ab_r_idle", busy, 1'b0);
      end
      // PHY never answers: done with err exactly TIMEOUT cycles after entering TXCMD.
      start(1'b1, 6'h11, 8'h22);
      k = 0; stp_n = 0;
      for (int c = 1; c <= 200 && k == 0; c++) begin
         cyc(1'b0, 1'b0, 8'h00);
         stp_n += int'(ulpi_stp);
         if (done) k = c;
      end
      chk("timeout_cycle", k, 1 + TIMEOUT);
      chk("timeout_err", err, 1'b1);
      chk("timeout_no_stp", stp_n, 0);
      cyc(1'b0, 1'b0, 8'h00);
      // Reset in the data phase abandons the write without stp.
      start(1'b1, 6'h04, 8'h45);
      cyc(1'b0, 1'b1, 8'h00);
      cyc(1'b0, 1'b0, 8'h00);
      chk("rst_mid_wdata", {cmd_strobe, cmd}, {1'b1, 8'h45});
      reset = 1'b1;
      cyc(1'b0, 1'b0, 8'h00);
      chk("rst_mid_ctrl", {busy, done, err, cmd_strobe, ulpi_stp}, 0);
      chk("rst_mid_data", {cmd, rdata}, 0);
      reset = 1'b0;
      cyc(1'b0, 1'b0, 8'h00);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
